sram_burst_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the burst_mode_sram (16x8).

---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/sram_arb_rr2.sv | 47 ++++
 rtl/sram_burst_arbiter.sv | 138 +++++++++++++
 tb/tb_sram_burst_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-requester SRAM burst arbiter.
// Holds the default geometry (16x8 SRAM, 4-bit burst length), the FSM state
// codes and the beat-counter width helper.
package sram_arb_pkg;

  localparam int AW_DEF = 4;  // SRAM address width, depth 2**AW
  localparam int DW_DEF = 8;  // data width
  localparam int LW_DEF = 4;  // burst-length field width, len==0 means 2**LW beats

  // The beat counter needs one extra bit so a 2**LW-beat burst never overflows.
  function automatic int cnt_width(input int lw);
    return lw + 1;
  endfunction

  localparam int CNT_W = cnt_width(LW_DEF);

  // Sequencer states, kept as plain constants for legacy tool flows.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way grant selector for the SRAM burst arbiter.
// Default: round-robin, a tie goes to the requester not granted last
// (last_grant resets to 1 so requester 0 wins the first tie).
// Macro SRAM_ARB_PRIO_EN: fixed priority, requester 0 always wins ties.
module sram_arb_rr2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef SRAM_ARB_PRIO_EN

  // Fixed priority: requester 0 beats requester 1.
  always_comb begin
    grant = 2'b00;
    if (valid[0])      grant = 2'b01;
    else if (valid[1]) grant = 2'b10;
  end

`else

  logic last_grant;
  logic pick;

  // Winner index: a lone requester wins, a tie goes to whoever lost last time.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves it unassigned (no latch).
    pick  = valid[1];
    grant = 2'b00;
    if (valid == 2'b11) pick = ~last_grant;
    if (valid != 2'b00) grant = pick ? 2'b10 : 2'b01;
  end

  // Remember the index granted by each accepted request.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so all flops update from pre-edge values.
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= pick;
  end

`endif

endmodule

// File: rtl/sram_burst_arbiter.sv
// Two-requester burst arbiter/sequencer in front of a single burst-mode SRAM.
// Grants whole bursts, then issues one SRAM beat per clock with an incrementing
// (wrapping) address. Write data is pulled from the granted requester beat by
// beat; read data comes back one cycle later with rvalid/rid.
// Macro SRAM_ARB_PRIO_EN selects fixed priority instead of round-robin.
module sram_burst_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*LW-1:0] req_len,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      wbeat,
  output logic            rvalid,
  output logic            rid,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      done,
  output logic            busy,
  output logic            sram_cs,
  output logic            sram_we,
  output logic [AW-1:0]   sram_addr,
  output logic [LW-1:0]   sram_burst_len,
  output logic [DW-1:0]   sram_din,
  input  logic [DW-1:0]   sram_dout
);

  localparam int CW = cnt_width(LW);

  logic [1:0]    state;
  logic [1:0]    grant;
  logic          accept;
  logic          cmd_id;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [CW-1:0] cnt;
  logic [CW-1:0] beats;
  logic          last_beat;
  logic          rd_pend;
  logic          rd_id;
  logic [1:0]    cmd_onehot;

  sram_arb_rr2 u_rr2 (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // A request is only taken in IDLE, and never while reset is asserted.
  assign accept    = (state == ST_IDLE) && (grant != 2'b00) && !rst;
  assign req_ready = accept ? grant : 2'b00;

  // len==0 encodes the full 2**LW burst.
  assign beats      = (cmd_len == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, cmd_len};
  assign last_beat  = (cnt == beats - CW'(1));
  assign cmd_onehot = cmd_id ? 2'b10 : 2'b01;

  // Sequencer: latch the granted command, step through its beats, drain reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cmd_id   <= 1'b0;
      cmd_we   <= 1'b0;
      cmd_addr <= '0;
      cmd_len  <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_id   <= grant[1];
            cmd_we   <= grant[1] ? req_we[1] : req_we[0];
            cmd_addr <= grant[1] ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
            cmd_len  <= grant[1] ? req_len[2*LW-1:LW] : req_len[LW-1:0];
            cnt      <= '0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          cnt <= cnt + CW'(1);
          if (last_beat) state <= cmd_we ? ST_IDLE : ST_DRAIN;
        end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Read-return pipe: SRAM data is valid the cycle after a read beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else begin
      rd_pend <= (state == ST_BURST) && !cmd_we;
      rd_id   <= cmd_id;
    end
  end

  // Beat-level SRAM drive, write-data pull and completion pulses.
  always_comb begin
    sram_cs   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    wbeat     = 2'b00;
    done      = 2'b00;
    if (state == ST_BURST) begin
      sram_cs   = 1'b1;
      sram_we   = cmd_we;
      sram_addr = cmd_addr + AW'(cnt);
      if (cmd_we) begin
        sram_din = cmd_id ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
        wbeat    = cmd_onehot;
        if (last_beat) done = cmd_onehot;
      end
    end else if (state == ST_DRAIN) begin
      done = cmd_onehot;
    end
  end

  assign busy           = (state != ST_IDLE);
  assign rvalid         = rd_pend;
  assign rid            = rd_pend & rd_id;
  assign rdata          = rd_pend ? sram_dout : '0;
  assign sram_burst_len = cmd_len;

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// Scoreboard bench for sram_burst_arbiter with a behavioural 16x8 burst SRAM.
// Expected grants, SRAM beats, read returns and done pulses are pushed when a
// request is issued (grant order from the arbitration rules, data from a
// reference memory); a negedge monitor pops and compares as the DUT responds.
module tb_sram_burst_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*LW-1:0] req_len = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      wbeat;
  logic            rvalid;
  logic            rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      done;
  logic            busy;
  logic            sram_cs;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [LW-1:0]   sram_burst_len;
  logic [DW-1:0]   sram_din;
  logic [DW-1:0]   sram_dout = '0;

  always #5 clk = ~clk;

  sram_burst_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .wbeat(wbeat), .rvalid(rvalid), .rid(rid), .rdata(rdata), .done(done), .busy(busy),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_burst_len(sram_burst_len), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Behavioural burst SRAM: synchronous write, registered read.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (sram_cs && sram_we)  mem[sram_addr] <= sram_din;
    if (sram_cs && !sram_we) sram_dout <= mem[sram_addr];
  end

  typedef struct {
    bit       we;
    bit [3:0] addr;
    bit [3:0] len;
    bit [7:0] data [16];
  } cmd_t;

  typedef struct packed {
    bit       id;
    bit       we;
    bit [3:0] addr;
    bit [3:0] len;
    bit [7:0] din;
    bit       first;
  } beat_t;

  typedef struct packed {
    bit       id;
    bit [7:0] data;
  } rd_t;

  int       exp_grant[$];
  beat_t    exp_beat[$];
  rd_t      exp_rd[$];
  int       exp_done[$];
  bit [7:0] wq0[$];
  bit [7:0] wq1[$];
  bit [7:0] ref_mem [16];
  bit       model_last = 1'b1;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int accept_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] got);
    tests++;
    failed++;
    $display("FAIL %s: got %0h, expected nothing (cycle %0d)", name, got, cyc);
  endtask

  function automatic int n_beats(input bit [3:0] len);
    return (len == 4'd0) ? 16 : int'(len);
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we   = 1'($urandom_range(0, 1));
    c.addr = 4'($urandom);
    c.len  = 4'($urandom);
    for (int k = 0; k < 16; k++) c.data[k] = 8'($urandom);
    return c;
  endfunction

  function automatic cmd_t mk(input bit we, input bit [3:0] addr, input bit [3:0] len);
    cmd_t c;
    c.we   = we;
    c.addr = addr;
    c.len  = len;
    for (int k = 0; k < 16; k++) c.data[k] = 8'h00;
    return c;
  endfunction

  // Reference model: one granted burst, optionally cut short by a reset
  // asserted during beat abort_at (beats 0..abort_at issue, no done).
  task automatic push_cmd(input bit g, input cmd_t c, input int abort_at);
    int    nb;
    beat_t b;
    rd_t   r;
    bit [3:0] a;
    nb = (abort_at >= 0) ? abort_at + 1 : n_beats(c.len);
    exp_grant.push_back(int'(g));
    for (int k = 0; k < nb; k++) begin
      a = c.addr + 4'(k);
      b.id = g; b.we = c.we; b.addr = a; b.len = c.len; b.first = (k == 0); b.din = 8'h00;
      if (c.we) begin
        ref_mem[a] = c.data[k];
        b.din = c.data[k];
        if (g) wq1.push_back(c.data[k]); else wq0.push_back(c.data[k]);
      end else if (abort_at < 0 || k < abort_at) begin
        r.id = g; r.data = ref_mem[a];
        exp_rd.push_back(r);
      end
      exp_beat.push_back(b);
    end
    if (abort_at < 0) exp_done.push_back(int'(g));
  endtask

  task automatic set_req(input bit g, input cmd_t c);
    if (g) begin
      req_we[1] = c.we; req_addr[7:4] = c.addr; req_len[7:4] = c.len;
    end else begin
      req_we[0] = c.we; req_addr[3:0] = c.addr; req_len[3:0] = c.len;
    end
    req_valid[g] = 1'b1;
  endtask

  // Expected order: lone requester goes first; a tie goes to the one not
  // granted last (requester 0 always when fixed priority is built in).
  task automatic issue_round(input bit has0, input cmd_t c0, input bit has1, input cmd_t c1);
    bit w;
    if (has0 && has1) begin
`ifdef SRAM_ARB_PRIO_EN
      w = 1'b0;
`else
      w = ~model_last;
`endif
      push_cmd(w, w ? c1 : c0, -1);
      push_cmd(~w, w ? c0 : c1, -1);
      model_last = ~w;
    end else if (has0) begin
      push_cmd(1'b0, c0, -1);
      model_last = 1'b0;
    end else if (has1) begin
      push_cmd(1'b1, c1, -1);
      model_last = 1'b1;
    end
    if (has0) set_req(1'b0, c0);
    if (has1) set_req(1'b1, c1);
  endtask

  task automatic wait_accepts();
    logic [1:0] drop;
    int budget = 300;
    while (req_valid != 2'b00 && budget > 0) begin
      @(negedge clk);
      drop = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~drop;
      budget--;
    end
    if (req_valid != 2'b00) begin
      flag("accept_timeout", req_valid);
      req_valid = 2'b00;
    end
  endtask

  task automatic wait_idle();
    int budget = 300;
    bit ok = 1'b0;
    while (!ok && budget > 0) begin
      @(negedge clk);
      ok = !busy && exp_grant.size() == 0 && exp_beat.size() == 0 &&
           exp_rd.size() == 0 && exp_done.size() == 0;
      budget--;
    end
    if (!ok) begin
      flag("idle_timeout", {exp_grant.size(), exp_beat.size(), exp_rd.size(), exp_done.size()});
      exp_grant.delete(); exp_beat.delete(); exp_rd.delete(); exp_done.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_round(input bit has0, input cmd_t c0, input bit has1, input cmd_t c1);
    issue_round(has0, c0, has1, c1);
    wait_accepts();
    wait_idle();
  endtask

  // Write-data feeder: advance a requester's data after each consumed beat.
  logic [1:0] wb_seen;
  always begin
    @(negedge clk);
    wb_seen = wbeat;
    @(posedge clk); #1;
    if (wb_seen[0] && wq0.size() != 0) void'(wq0.pop_front());
    if (wb_seen[1] && wq1.size() != 0) void'(wq1.pop_front());
    req_wdata = {(wq1.size() != 0) ? wq1[0] : 8'h00, (wq0.size() != 0) ? wq0[0] : 8'h00};
  end

  // Monitor: compare every DUT event against the head of its queue.
  int    mg;
  beat_t mb;
  rd_t   mr;
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != 2'b00) begin
        if (exp_grant.size() == 0) flag("grant_unexpected", req_ready);
        else begin
          mg = exp_grant.pop_front();
          check("grant", req_ready, (mg == 1) ? 2'b10 : 2'b01);
        end
        accept_cyc = cyc;
      end
      if (sram_cs) begin
        if (exp_beat.size() == 0) flag("beat_unexpected", sram_addr);
        else begin
          mb = exp_beat.pop_front();
          check("beat_addr", sram_addr, mb.addr);
          check("beat_we", sram_we, mb.we);
          check("burst_len", sram_burst_len, mb.len);
          check("busy_in_burst", busy, 1);
          if (mb.we) begin
            check("wdata", sram_din, mb.din);
            check("wbeat", wbeat, mb.id ? 2'b10 : 2'b01);
          end else begin
            check("wbeat_on_read", wbeat, 0);
          end
          if (mb.first) check("issue_latency", cyc - accept_cyc, 1);
        end
      end else if (wbeat != 2'b00) begin
        check("wbeat_idle", wbeat, 0);
      end
      if (rvalid) begin
        if (exp_rd.size() == 0) flag("rvalid_unexpected", rdata);
        else begin
          mr = exp_rd.pop_front();
          check("rid", rid, mr.id);
          check("rdata", rdata, mr.data);
        end
      end
      if (done != 2'b00) begin
        if (exp_done.size() == 0) flag("done_unexpected", done);
        else begin
          mg = exp_done.pop_front();
          check("done", done, (mg == 1) ? 2'b10 : 2'b01);
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", tests, failed);
    $fatal(1);
  end

  initial begin
    cmd_t c0, c1;
    cmd_t bb [6];
    int   t [6];
    int   idx, budget, n;
    bit   h0, h1;

    repeat (3) @(posedge clk);
    #1;

    // Contention from reset: both valid while reset is still held.
    c0 = rand_cmd(); c0.we = 1'b1; c0.addr = 4'd2; c0.len = 4'd2;
    c1 = rand_cmd(); c1.we = 1'b1; c1.addr = 4'd9; c1.len = 4'd3;
    issue_round(1'b1, c0, 1'b1, c1);
    @(negedge clk);
    check("reset_outputs", {req_ready, wbeat, rvalid, rid, rdata, done, busy, sram_cs,
                            sram_we, sram_addr, sram_burst_len, sram_din}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_accepts();
    wait_idle();

    // Fill the whole SRAM with a 16-beat write that wraps.
    c1 = rand_cmd(); c1.we = 1'b1; c1.addr = 4'd5; c1.len = 4'd0;
    run_round(1'b0, c1, 1'b1, c1);

    // Single write then read back.
    c0 = mk(1'b1, 4'd3, 4'd1); c0.data[0] = 8'hA5;
    run_round(1'b1, c0, 1'b0, c0);
    c0 = mk(1'b0, 4'd3, 4'd1);
    run_round(1'b1, c0, 1'b0, c0);

    // Four-beat write/read from requester 1.
    c1 = mk(1'b1, 4'd4, 4'd4);
    c1.data[0] = 8'hC7; c1.data[1] = 8'hC8; c1.data[2] = 8'hC9; c1.data[3] = 8'hCA;
    run_round(1'b0, c1, 1'b1, c1);
    c1 = mk(1'b0, 4'd4, 4'd4);
    run_round(1'b0, c1, 1'b1, c1);

    // Address wrap and a full 16-beat read.
    c0 = rand_cmd(); c0.we = 1'b1; c0.addr = 4'd14; c0.len = 4'd3;
    run_round(1'b1, c0, 1'b0, c0);
    c0 = mk(1'b0, 4'd0, 4'd0);
    run_round(1'b1, c0, 1'b0, c0);

    // Randomised rounds, including repeated ties.
    for (int r = 0; r < 40; r++) begin
      h0 = 1'($urandom_range(0, 1));
      h1 = 1'($urandom_range(0, 1));
      if (!h0 && !h1) h0 = 1'b1;
      c0 = rand_cmd();
      c1 = rand_cmd();
      run_round(h0, c0, h1, c1);
    end

    // Reset during beat 2 of a 6-beat read.
    c0 = mk(1'b0, 4'($urandom), 4'd6);
    push_cmd(1'b0, c0, 2);
    set_req(1'b0, c0);
    wait_accepts();
    n = 0;
    budget = 50;
    while (n < 3 && budget > 0) begin
      @(negedge clk);
      if (sram_cs) n++;
      budget--;
    end
    if (n < 3) flag("abort_beat_timeout", n);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs", {req_ready, wbeat, rvalid, rid, rdata, done, busy, sram_cs,
                            sram_we, sram_addr, sram_burst_len, sram_din}, 0);
    model_last = 1'b1;
    rst = 1'b0;
    wait_idle();

    // Back-to-back bursts from requester 0 with valid held high.
    for (int i = 0; i < 6; i++) begin
      bb[i] = rand_cmd();
      push_cmd(1'b0, bb[i], -1);
    end
    model_last = 1'b0;
    set_req(1'b0, bb[0]);
    idx = 0;
    budget = 400;
    while (idx < 6 && budget > 0) begin
      @(negedge clk);
      if (req_ready[0]) begin
        t[idx] = cyc;
        idx++;
        @(posedge clk); #1;
        if (idx < 6) set_req(1'b0, bb[idx]);
        else req_valid[0] = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      budget--;
    end
    if (idx < 6) begin
      flag("b2b_timeout", idx);
      req_valid = 2'b00;
    end
    for (int i = 1; i < idx; i++)
      check("b2b_gap", t[i] - t[i-1], n_beats(bb[i-1].len) + 1 + (bb[i-1].we ? 0 : 1));
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
